// File: rtl/hazard_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_unit_if
//   Bundles every pipeline-side signal exchanged with the hazard unit.
//
//   Pipeline -> hazard unit (driven through the master modport):
//     rsD, rtD               source registers of the decode-stage instruction
//     rsE, rtE               source registers of the execute-stage instruction
//     writeregE/M/W          destination register carried by each stage
//     regwriteE/M/W          stage will write the register file
//     memtoregE/M            stage holds a load
//     branchD                decode holds a branch that compares registers
//     divE                   execute holds a divide
//     memaccessM, dmem_okM   memory-stage access and its completion strobe
//
//   Hazard unit -> pipeline (driven through the slave modport):
//     forwardAD/BD           decode comparator bypass from M
//     forwardAE/BE           ALU operand select (00 regfile, 01 W, 10 M)
//     stallF/D/E/M           pipeline register hold enables
//     flushE, flushW         pipeline register clears
//     div_busy, div_done     divider running / divider result valid
// ---------------------------------------------------------------------------
interface hazard_unit_if;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [4:0] rsE;
  logic [4:0] rtE;
  logic [4:0] writeregE;
  logic [4:0] writeregM;
  logic [4:0] writeregW;
  logic       regwriteE;
  logic       regwriteM;
  logic       regwriteW;
  logic       memtoregE;
  logic       memtoregM;
  logic       branchD;
  logic       divE;
  logic       memaccessM;
  logic       dmem_okM;

  logic       forwardAD;
  logic       forwardBD;
  logic [1:0] forwardAE;
  logic [1:0] forwardBE;
  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       stallM;
  logic       flushE;
  logic       flushW;
  logic       div_busy;
  logic       div_done;

  // Datapath/controller side: supplies register numbers and flags,
  // consumes the bypass selects and stall/flush controls.
  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
    output branchD, divE, memaccessM, dmem_okM,
    input  forwardAD, forwardBD, forwardAE, forwardBE,
    input  stallF, stallD, stallE, stallM, flushE, flushW,
    input  div_busy, div_done
  );

  // Hazard unit side.
  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
    input  branchD, divE, memaccessM, dmem_okM,
    output forwardAD, forwardBD, forwardAE, forwardBE,
    output stallF, stallD, stallE, stallM, flushE, flushW,
    output div_busy, div_done
  );
endinterface

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//   Forwarding and stall/flush control for a five-stage MIPS-style pipeline
//   with a multi-cycle divider in execute and a data memory that can wait.
//
//   Parameters:
//     DIV_CYCLES  number of cycles the divider spends busy (legal 2..63)
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-low reset
//     hz    hazard_unit_if.slave, all pipeline-facing signals
//
//   Hazard sources:
//     lwStall   load in E feeds an instruction in D
//     brStall   branch in D needs a value still in E, or a load still in M
//     memStall  data memory has not completed the access in M
//     divStall  divide being started or running in E
//
//   Execute-stage freezes (divide, memory wait) take priority over the
//   decode-stage bubble: while E is frozen, F/D simply hold and the bubble
//   is injected into E on the first cycle E is free again.
// ---------------------------------------------------------------------------
module hazard_unit #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  hz
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;

  // Last count value spent in DIV_RUN; counting 0..DIV_CYCLES-1 gives
  // exactly DIV_CYCLES busy cycles.
  localparam logic [5:0] LAST_CNT = 6'(DIV_CYCLES - 1);

  divState_t  state_q;
  logic [5:0] cnt_q;
  logic [5:0] cnt_d;
  logic       busy_q;
  logic       done_q;

  logic       lwStall;
  logic       brStall;
  logic       memStall;
  logic       divStall;
  logic       stallExec;
  logic       decodeHazard;

  logic [1:0] fwdAE;
  logic [1:0] fwdBE;
  logic       fwdAD;
  logic       fwdBD;

  // ALU operand bypass select for one source register. Register 0 is
  // hard-wired to zero and never forwarded. M is checked first because it
  // holds the younger result when both M and W target the same register.
  function automatic logic [1:0] aluFwdSel(
    input logic [4:0] src,
    input logic       rwM,
    input logic [4:0] wrM,
    input logic       rwW,
    input logic [4:0] wrW
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd0) begin
      if (rwM && (src == wrM)) begin
        sel = 2'b10;
      end else if (rwW && (src == wrW)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  // Decode comparator bypass from M for one source register.
  function automatic logic decFwdSel(
    input logic [4:0] src,
    input logic       rwM,
    input logic [4:0] wrM
  );
    return (src != 5'd0) && rwM && (src == wrM);
  endfunction

  // Forwarding selects for both E operands and both D comparator inputs.
  always_comb begin
    fwdAE = aluFwdSel(hz.rsE, hz.regwriteM, hz.writeregM,
                      hz.regwriteW, hz.writeregW);
    fwdBE = aluFwdSel(hz.rtE, hz.regwriteM, hz.writeregM,
                      hz.regwriteW, hz.writeregW);
    fwdAD = decFwdSel(hz.rsD, hz.regwriteM, hz.writeregM);
    fwdBD = decFwdSel(hz.rtD, hz.regwriteM, hz.writeregM);
  end

  // Hazard detection. The divide term looks only at the registered state,
  // so during reset it evaluates as IDLE.
  always_comb begin
    lwStall  = hz.memtoregE &&
               ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD));

    brStall  = hz.branchD &&
               ((hz.regwriteE &&
                 ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
                (hz.memtoregM &&
                 ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD))));

    memStall = hz.memaccessM && !hz.dmem_okM;

    divStall = ((state_q == IDLE) && hz.divE) || (state_q == DIV_RUN);

    stallExec    = divStall || memStall;
    decodeHazard = lwStall || brStall;
  end

  // Incremented counter value used while the divider is running.
  always_comb begin
    cnt_d = cnt_q + 6'd1;
  end

  // Divider sequencer. A divide starts only when M is not waiting, runs for
  // DIV_CYCLES cycles, then holds DIV_DONE until the memory stage releases,
  // so the divide instruction (still in E, still asserting divE) cannot
  // retrigger itself. busy/done are registered copies of the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hz.divE && !memStall) begin
            state_q <= DIV_RUN;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        DIV_RUN: begin
          // Count saturates at LAST_CNT; leaving the state here keeps the
          // counter from ever wrapping.
          if (cnt_q == LAST_CNT) begin
            state_q <= DIV_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        DIV_DONE: begin
          if (!memStall) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 6'd0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output drive. flushE is masked by stallExec so E is never cleared while
  // it is also being held; the pending load-use or branch bubble is then
  // inserted once E is free.
  assign hz.forwardAE = fwdAE;
  assign hz.forwardBE = fwdBE;
  assign hz.forwardAD = fwdAD;
  assign hz.forwardBD = fwdBD;

  assign hz.stallE    = stallExec;
  assign hz.stallM    = memStall;
  assign hz.flushW    = memStall;
  assign hz.stallF    = decodeHazard || stallExec;
  assign hz.stallD    = decodeHazard || stallExec;
  assign hz.flushE    = decodeHazard && !stallExec;

  assign hz.div_busy  = busy_q;
  assign hz.div_done  = done_q;

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
//   Directed bench for hazard_unit with DIV_CYCLES = 4. Inputs change 2 time
//   units after a rising edge and outputs are sampled 1 unit later, well
//   away from the next edge.
// ---------------------------------------------------------------------------
module tb_hazard_unit;

  localparam logic [8:0] RWE  = 9'h100;
  localparam logic [8:0] RWM  = 9'h080;
  localparam logic [8:0] RWW  = 9'h040;
  localparam logic [8:0] MTRE = 9'h020;
  localparam logic [8:0] MTRM = 9'h010;
  localparam logic [8:0] BR   = 9'h008;
  localparam logic [8:0] DIV  = 9'h004;
  localparam logic [8:0] MA   = 9'h002;
  localparam logic [8:0] DOK  = 9'h001;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hazard_unit_if hz ();

  hazard_unit #(.DIV_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  // Free-running clock, first rising edge at time 5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Backstop so the run always ends even if sequencing goes wrong.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive every pipeline input; flags packs the 1-bit controls.
  task automatic applyStimulus(
    input logic [4:0] rsD, input logic [4:0] rtD,
    input logic [4:0] rsE, input logic [4:0] rtE,
    input logic [4:0] wE,  input logic [4:0] wM, input logic [4:0] wW,
    input logic [8:0] flags
  );
    hz.rsD        = rsD;
    hz.rtD        = rtD;
    hz.rsE        = rsE;
    hz.rtE        = rtE;
    hz.writeregE  = wE;
    hz.writeregM  = wM;
    hz.writeregW  = wW;
    hz.regwriteE  = flags[8];
    hz.regwriteM  = flags[7];
    hz.regwriteW  = flags[6];
    hz.memtoregE  = flags[5];
    hz.memtoregM  = flags[4];
    hz.branchD    = flags[3];
    hz.divE       = flags[2];
    hz.memaccessM = flags[1];
    hz.dmem_okM   = flags[0];
    #1;
  endtask

  // Compare all outputs at once against hand-computed values.
  // Order: forwardAE forwardBE forwardAD forwardBD stallF stallD stallE
  //        stallM flushE flushW div_busy div_done
  task automatic checkOutput(
    input string      tag,
    input logic [1:0] eAE, input logic [1:0] eBE,
    input logic eAD, input logic eBD,
    input logic eF,  input logic eD, input logic eE, input logic eM,
    input logic eFE, input logic eFW,
    input logic eBusy, input logic eDone
  );
    logic [13:0] obsVec;
    logic [13:0] expVec;
    obsVec = {hz.forwardAE, hz.forwardBE, hz.forwardAD, hz.forwardBD,
              hz.stallF, hz.stallD, hz.stallE, hz.stallM,
              hz.flushE, hz.flushW, hz.div_busy, hz.div_done};
    expVec = {eAE, eBE, eAD, eBD, eF, eD, eE, eM, eFE, eFW, eBusy, eDone};
    checks++;
    assert (obsVec === expVec) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obsVec, expVec);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // ---------------- reset behaviour ----------------
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9'h000);
    tick();
    checkOutput("reset_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, DIV);
    checkOutput("reset_comb",   0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    tick();
    checkOutput("reset_hold",   0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9'h000);
    rst = 1'b1;
    tick();
    checkOutput("post_reset",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- forwarding ----------------
    applyStimulus(0, 0, 5, 5, 0, 5, 5, RWM | RWW);
    checkOutput("fwd_m_wins",   2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 5, 0, 0, 5, RWW);
    checkOutput("fwd_r0_and_w", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 5, 7, 0, 7, 5, RWM | RWW);
    checkOutput("fwd_w_and_m",  1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(5, 0, 0, 0, 0, 5, 0, RWM);
    checkOutput("fwd_decode",   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, RWM | RWW);
    checkOutput("fwd_reg_zero", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- load-use ----------------
    tick();
    applyStimulus(8, 0, 0, 8, 0, 0, 0, MTRE);
    checkOutput("lw_rs",        0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    tick();
    applyStimulus(8, 0, 0, 0, 0, 0, 0, 9'h000);
    checkOutput("lw_bubble",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 8, 0, 8, 0, 0, 0, MTRE);
    checkOutput("lw_rt",        0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(2, 3, 0, 8, 0, 0, 0, MTRE);
    checkOutput("lw_nomatch",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- branch ----------------
    tick();
    applyStimulus(0, 3, 0, 0, 3, 0, 0, BR | RWE);
    checkOutput("br_from_e",    0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 3, 0, 0, 0, 3, 0, BR | RWM);
    checkOutput("br_fwd_m",     0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 3, 0, 0, 0, 3, 0, BR | RWM | MTRM);
    checkOutput("br_load_m",    0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 3, 0, 0, 3, 0, 0, RWE);
    checkOutput("br_nobranch",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- plain divide ----------------
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, DIV);
    checkOutput("div_start",    0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("div_run",    0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    end
    tick();
    checkOutput("div_done",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9'h000);
    tick();
    checkOutput("div_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- divide with memory waits ----------------
    applyStimulus(0, 0, 0, 0, 0, 0, 0, DIV | MA);
    checkOutput("idle_memwait", 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 0);
    tick();
    checkOutput("idle_nostart", 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, DIV);
    checkOutput("mdiv_start",   0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("mdiv_run",   0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, DIV | MA);
    checkOutput("done_wait0",   0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 1);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("done_waitN", 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 1);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, DIV | MA | DOK);
    checkOutput("done_release", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9'h000);
    tick();
    checkOutput("mdiv_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- load-use during divide, abort by reset ----------------
    applyStimulus(8, 0, 0, 8, 0, 0, 0, DIV | MTRE);
    checkOutput("lwdiv_start",  0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("lwdiv_run",  0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    end
    rst = 1'b0;
    #1;
    checkOutput("abort_async",  0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    tick();
    checkOutput("abort_hold",   0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("redo_run",   0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    end
    tick();
    checkOutput("redo_bubble",  0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9'h000);
    tick();
    checkOutput("final_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
